util_rr_arbiter: RTL and testbench
==================================

# util_rr_arbiter

Round-robin arbiter that shares one resource, such as a bus or a peripheral port, between up to N requesters. Request lines are synchronous to `clk`; asynchronous sources pass through `util_sync_domain` first. A grant is held until the owner releases its request or a programmable hold limit expires. On expiry the owner is pre-empted and locked out until it drops its request. Single-cycle start, end and timeout strobes are provided for downstream sequencing logic.

## Interface
- `N`, default 4: number of requesters, 2..16.
- `MAX_HOLD`, default 0: maximum grant length in cycles; 0 means unlimited.
- `IW`, default `$clog2(N)`: width of the grant index.
- `clk`  in  1: system clock; all logic is on the rising edge.
- `res`  in  1: asynchronous, active-high reset.
- `req`  in  N: request per requester; level; synchronous to `clk`.
- `gnt`  out  N: one-hot grant, registered.
- `gnt_valid`  out  1: OR of `gnt`, registered.
- `gnt_idx`  out  IW: index of the current or most recent owner, registered.
- `gnt_start`  out  1: 1-cycle strobe in the first cycle a grant is high.
- `gnt_end`  out  1: 1-cycle strobe in the first cycle after a grant drops.
- `timeout`  out  1: 1-cycle strobe, coincident with `gnt_end`, when the drop was a pre-emption.

## Operation
- **State:**
  - FSM with two states: IDLE and OWN.
  - Registers:
    - `last`: IW bits, the last granted index.
    - `blocked`: N bits.
    - `hold_cnt`: holds at least the value MAX_HOLD-1.
- **Eligibility:** `elig = req & ~blocked`.
- **IDLE, no eligible request:** if `elig` = 0, stay in IDLE.
- **IDLE, arbitration:** otherwise pick the first set bit of `elig`, searching from `last+1` upward modulo N.
  - Set `gnt[winner]`.
  - Set `gnt_idx` and `last` to the winner.
  - Set `hold_cnt` to 0.
  - Go to OWN.
- **OWN, release:** if `req[last]` = 0, clear `gnt` and go to IDLE.
- **OWN, timeout:** if `MAX_HOLD` != 0, `req[last]` = 1 and `hold_cnt` = MAX_HOLD-1:
  - clear `gnt`;
  - set `blocked[last]`;
  - pulse `timeout`;
  - go to IDLE.
- **OWN, otherwise:** increment `hold_cnt`. The counter saturates and does not wrap when `MAX_HOLD` = 0.
- **Blocked bits:** `blocked[i]` clears on any edge where `req[i]` = 0, in either state. A blocked requester never wins.
- **Gap between owners:** IDLE always lasts at least one cycle between owners. `gnt` is low for at least one cycle between any two grants, including a re-grant to the same requester.
- **Request edge cases:**
  - Requests that rise and fall while another requester owns the grant are not remembered.
  - A non-owner's request changes have no effect during OWN.
- **Round-robin order:** after requester i is served, i has the lowest priority at the next arbitration. No requester waits more than N-1 grants.
- **Reset values:**
  - `gnt` = 0, `gnt_valid` = 0, `gnt_idx` = 0.
  - `gnt_start` = 0, `gnt_end` = 0, `timeout` = 0.
  - `blocked` = 0, `hold_cnt` = 0.
  - `last` = N-1, so requester 0 wins first.
  - State = IDLE.
- **Reset during OWN:** `gnt` drops immediately and asynchronously, with no `gnt_end` strobe.

## Timing
- **Grant latency:** `req` sampled high at edge t in IDLE gives `gnt` high after edge t. Latency is 1 cycle from the registered request.
- **Start strobe:** `gnt_start` is high for exactly the first cycle of `gnt`.
- **Release:** `req[owner]` sampled low at edge t gives `gnt` low after edge t. `gnt_end` is high for the cycle after edge t.
- **Earliest next grant:** at edge t+1.
- **Timeout length:** with `MAX_HOLD` = M, `gnt` is high for exactly M cycles when never released.
- **Timeout strobes:** `timeout` and `gnt_end` assert together in cycle M+1.
- **Release and timeout on the same edge:** release wins. `timeout` stays 0 and `blocked` is not set.
- **Combinational paths:** none from `req` to any output; all outputs are registered.
- **Index and valid:** `gnt_idx` holds after the drop. `gnt_valid` follows `gnt` in the same cycle.

## Test plan
1. **Reset and first grant:**
   - Stimulus: hold `res` high, then release it; drive `req`=4'b1111 on the next edge.
   - Response: outputs are 0 during reset. `gnt`=0001 and `gnt_start`=1 one cycle after the first sampled edge.
2. **Rotation:**
   - Stimulus: `req`=1111; each owner drops its request 3 cycles after its grant and re-raises it 1 cycle later.
   - Response: grant order is 0,1,2,3,0. Exactly 1 low cycle of `gnt` separates grants. `gnt_end` pulses once per grant.
3. **Timeout pre-emption, MAX_HOLD=8:**
   - Stimulus: `req`=0100 held forever; `req[0]` rises at cycle 3.
   - Response: `gnt[2]` is high for exactly 8 cycles, then `timeout`=1 and `gnt_end`=1. `gnt`=0001 follows next. Requester 2 is never re-granted until `req[2]` is dropped for at least 1 cycle.
4. **Same-edge release and timeout:**
   - Stimulus: the owner drops `req` on the edge where `hold_cnt`=7.
   - Response: `timeout`=0 and `blocked`=0. The requester is eligible again when it re-raises.
5. **Sparse requests:**
   - Stimulus: `last`=1, `req`=1001.
   - Response: requester 3 wins, since the search starts at 2; requester 0 wins next.
6. **Reset mid-grant:**
   - Stimulus: assert `res` asynchronously mid-cycle while `gnt[1]`=1.
   - Response: `gnt` goes to 0 immediately with no `gnt_end` strobe. The first grant after reset goes to the lowest-index requester.

Source files
------------

// File: rtl/util_rr_arbiter.sv
// Round-robin arbiter for up to N requesters with an optional hold limit.
// An owner that exceeds the limit is pre-empted and locked out until it drops its request.
//
// state  | meaning
// S_IDLE | no grant; arbitrate among eligible requests
// S_OWN  | gnt[last] held; watch for release or hold expiry
module util_rr_arbiter #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 0,
    parameter int IW       = $clog2(N)
) (
    input  logic          clk,
    input  logic          res,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  gnt,
    output logic          gnt_valid,
    output logic [IW-1:0] gnt_idx,
    output logic          gnt_start,
    output logic          gnt_end,
    output logic          timeout
);
    localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LAST = (MAX_HOLD > 0) ? HW'(MAX_HOLD - 1) : '1;

    typedef enum logic {S_IDLE, S_OWN} state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] last_q, last_d;
    logic [N-1:0]  blocked_q, blocked_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic [N-1:0]  gnt_q, gnt_d;
    logic          gnt_valid_q, gnt_valid_d;
    logic [IW-1:0] gnt_idx_q, gnt_idx_d;
    logic          gnt_start_q, gnt_start_d;
    logic          gnt_end_q, gnt_end_d;
    logic          timeout_q, timeout_d;

    logic [N-1:0]  elig;
    logic          found;
    logic [IW-1:0] win;
    logic [IW-1:0] cand;
    logic          hold_expire;

    // Search starts just above the last owner so it gets lowest priority.
    always_comb begin
        elig  = req & ~blocked_q;
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int k = 1; k <= N; k++) begin
            cand = IW'((int'(last_q) + k) % N);
            if (!found && elig[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    assign hold_expire = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_LAST);

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state_q     <= S_IDLE;
            last_q      <= IW'(N - 1);
            blocked_q   <= '0;
            hold_cnt_q  <= '0;
            gnt_q       <= '0;
            gnt_valid_q <= 1'b0;
            gnt_idx_q   <= '0;
            gnt_start_q <= 1'b0;
            gnt_end_q   <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            blocked_q   <= blocked_d;
            hold_cnt_q  <= hold_cnt_d;
            gnt_q       <= gnt_d;
            gnt_valid_q <= gnt_valid_d;
            gnt_idx_q   <= gnt_idx_d;
            gnt_start_q <= gnt_start_d;
            gnt_end_q   <= gnt_end_d;
            timeout_q   <= timeout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (found) state_d = S_OWN;
            S_OWN:   if (!req[last_q] || hold_expire) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        last_d      = last_q;
        blocked_d   = blocked_q & req;
        hold_cnt_d  = hold_cnt_q;
        gnt_d       = gnt_q;
        gnt_idx_d   = gnt_idx_q;
        gnt_start_d = 1'b0;
        gnt_end_d   = 1'b0;
        timeout_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    gnt_d       = '0;
                    gnt_d[win]  = 1'b1;
                    gnt_idx_d   = win;
                    last_d      = win;
                    hold_cnt_d  = '0;
                    gnt_start_d = 1'b1;
                end
            end
            S_OWN: begin
                // Release is checked first so a same-edge drop is never a timeout.
                if (!req[last_q]) begin
                    gnt_d     = '0;
                    gnt_end_d = 1'b1;
                end else if (hold_expire) begin
                    gnt_d             = '0;
                    gnt_end_d         = 1'b1;
                    timeout_d         = 1'b1;
                    blocked_d[last_q] = 1'b1;
                end else if (hold_cnt_q != '1) begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            default: gnt_d = '0;
        endcase
        gnt_valid_d = |gnt_d;
    end

    assign gnt       = gnt_q;
    assign gnt_valid = gnt_valid_q;
    assign gnt_idx   = gnt_idx_q;
    assign gnt_start = gnt_start_q;
    assign gnt_end   = gnt_end_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_util_rr_arbiter.sv
// Bench for util_rr_arbiter: directed scenarios plus randomized requests
// compared against a cycle-level behavioural model of the arbitration rules.
module tb_util_rr_arbiter;
    localparam int N    = 4;
    localparam int MAXH = 8;
    localparam int IW   = 2;

    logic          clk = 1'b0;
    logic          res;
    logic [N-1:0]  req;
    logic [N-1:0]  gnt;
    logic          gnt_valid;
    logic [IW-1:0] gnt_idx;
    logic          gnt_start;
    logic          gnt_end;
    logic          timeout;

    util_rr_arbiter #(.N(N), .MAX_HOLD(MAXH), .IW(IW)) dut (
        .clk       (clk),
        .res       (res),
        .req       (req),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx),
        .gnt_start (gnt_start),
        .gnt_end   (gnt_end),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: owner index (-1 = none), cycles granted so far, lockout flags.
    int m_owner;
    int m_last;
    int m_len;
    int m_idx;
    bit m_blocked [N];
    bit m_start, m_end, m_to;

    task automatic model_reset();
        m_owner = -1;
        m_last  = N - 1;
        m_len   = 0;
        m_idx   = 0;
        m_start = 0;
        m_end   = 0;
        m_to    = 0;
        for (int i = 0; i < N; i++) m_blocked[i] = 0;
    endtask

    task automatic model_update(input logic [N-1:0] r);
        int base;
        int c;
        bit found;
        m_start = 0;
        m_end   = 0;
        m_to    = 0;
        if (m_owner < 0) begin
            base  = m_last;
            found = 0;
            for (int k = 1; k <= N; k++) begin
                c = (base + k) % N;
                if (!found && r[c] && !m_blocked[c]) begin
                    found   = 1;
                    m_owner = c;
                    m_last  = c;
                    m_idx   = c;
                    m_len   = 1;
                    m_start = 1;
                end
            end
        end else if (!r[m_owner]) begin
            m_end   = 1;
            m_owner = -1;
        end else if (MAXH != 0 && m_len == MAXH) begin
            m_end              = 1;
            m_to               = 1;
            m_blocked[m_owner] = 1;
            m_owner            = -1;
        end else begin
            m_len++;
        end
        for (int i = 0; i < N; i++) if (!r[i]) m_blocked[i] = 0;
    endtask

    task automatic step(input logic [N-1:0] r);
        req = r;
        @(posedge clk);
        model_update(r);
        @(negedge clk);
    endtask

    task automatic do_reset();
        res = 1'b1;
        req = '0;
        repeat (2) @(negedge clk);
        res = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        res = 1'b1;
        req = '1;
        repeat (2) @(negedge clk);
        n_total++;
        if ({gnt, gnt_valid, gnt_idx, gnt_start, gnt_end, timeout} !== '0)
            $display("FAIL reset_outputs got gnt=%b v=%b idx=%0d s=%b e=%b to=%b want all 0",
                     gnt, gnt_valid, gnt_idx, gnt_start, gnt_end, timeout);
        else n_pass++;
        res = 1'b0;
        model_reset();
        step(4'b1111);
        n_total++;
        if (gnt !== 4'b0001 || gnt_start !== 1'b1 || gnt_valid !== 1'b1)
            $display("FAIL first_grant gnt=%b start=%b valid=%b want 0001/1/1", gnt, gnt_start, gnt_valid);
        else n_pass++;
        step(4'b1111);
        n_total++;
        if (gnt_start !== 1'b0 || gnt !== 4'b0001)
            $display("FAIL start_one_cycle gnt=%b start=%b want 0001/0", gnt, gnt_start);
        else n_pass++;
    endtask

    task automatic test_rotation();
        int order[$];
        int exp_order[5] = '{0, 1, 2, 3, 0};
        int gcyc, low_run, gaps_bad, ends;
        logic [N-1:0] r;
        do_reset();
        r = '1; gcyc = 0; low_run = 0; gaps_bad = 0; ends = 0;
        for (int c = 0; c < 60 && order.size() < 5; c++) begin
            step(r);
            if (gnt_end) ends++;
            if (gnt_start) begin
                order.push_back(int'(gnt_idx));
                if (order.size() > 1 && low_run != 1) gaps_bad++;
                gcyc = 1;
                low_run = 0;
            end else if (gnt_valid) gcyc++;
            else low_run++;
            r = '1;
            if (gnt_valid && gcyc == 3) r[gnt_idx] = 1'b0;
        end
        n_total++;
        if (order.size() != 5) $display("FAIL rotation_count got %0d grants want 5", order.size());
        else n_pass++;
        for (int i = 0; i < 5 && i < order.size(); i++) begin
            n_total++;
            if (order[i] != exp_order[i])
                $display("FAIL rotation_order[%0d] got %0d want %0d", i, order[i], exp_order[i]);
            else n_pass++;
        end
        n_total++;
        if (gaps_bad != 0) $display("FAIL rotation_gap bad_gaps=%0d want 0", gaps_bad);
        else n_pass++;
        n_total++;
        if (ends != 4) $display("FAIL rotation_end_pulses got %0d want 4", ends);
        else n_pass++;
    endtask

    task automatic test_timeout();
        int high, c, seen2;
        logic [N-1:0] r;
        do_reset();
        r = 4'b0100;
        step(r);
        n_total++;
        if (gnt !== 4'b0100 || gnt_start !== 1'b1)
            $display("FAIL to_grant2 gnt=%b start=%b want 0100/1", gnt, gnt_start);
        else n_pass++;
        high = 1; c = 0;
        while (gnt === 4'b0100 && c < 20) begin
            c++;
            if (c == 2) r = 4'b0101;
            step(r);
            if (gnt === 4'b0100) high++;
        end
        n_total++;
        if (high != MAXH) $display("FAIL to_hold_len got %0d want %0d", high, MAXH);
        else n_pass++;
        n_total++;
        if (timeout !== 1'b1 || gnt_end !== 1'b1 || gnt !== 4'b0000)
            $display("FAIL to_strobes to=%b end=%b gnt=%b want 1/1/0000", timeout, gnt_end, gnt);
        else n_pass++;
        step(r);
        n_total++;
        if (gnt !== 4'b0001) $display("FAIL to_next_owner gnt=%b want 0001", gnt);
        else n_pass++;
        seen2 = 0;
        for (int i = 0; i < 12; i++) begin
            step(4'b0100);
            if (gnt[2] === 1'b1) seen2++;
        end
        n_total++;
        if (seen2 != 0) $display("FAIL to_lockout gnt2_cycles=%0d want 0", seen2);
        else n_pass++;
        step(4'b0000);
        step(4'b0100);
        n_total++;
        if (gnt !== 4'b0100) $display("FAIL to_unlock gnt=%b want 0100", gnt);
        else n_pass++;
    endtask

    task automatic test_same_edge();
        do_reset();
        step(4'b0010);
        for (int i = 0; i < 7; i++) step(4'b0010);
        n_total++;
        if (gnt !== 4'b0010) $display("FAIL same_edge_pre gnt=%b want 0010", gnt);
        else n_pass++;
        step(4'b0000);
        n_total++;
        if (timeout !== 1'b0 || gnt_end !== 1'b1 || gnt !== 4'b0000)
            $display("FAIL same_edge_release to=%b end=%b gnt=%b want 0/1/0000", timeout, gnt_end, gnt);
        else n_pass++;
        step(4'b0010);
        n_total++;
        if (gnt !== 4'b0010) $display("FAIL same_edge_regrant gnt=%b want 0010", gnt);
        else n_pass++;
    endtask

    task automatic test_sparse();
        do_reset();
        step(4'b0010);
        step(4'b0000);
        step(4'b1001);
        n_total++;
        if (gnt !== 4'b1000 || gnt_idx !== 2'd3)
            $display("FAIL sparse_first gnt=%b idx=%0d want 1000/3", gnt, gnt_idx);
        else n_pass++;
        step(4'b0001);
        n_total++;
        if (gnt !== 4'b0000 || gnt_idx !== 2'd3)
            $display("FAIL sparse_idx_hold gnt=%b idx=%0d want 0000/3", gnt, gnt_idx);
        else n_pass++;
        step(4'b0001);
        n_total++;
        if (gnt !== 4'b0001) $display("FAIL sparse_second gnt=%b want 0001", gnt);
        else n_pass++;
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        step(4'b0011);
        step(4'b0010);
        step(4'b0010);
        n_total++;
        if (gnt !== 4'b0010) $display("FAIL midrst_pre gnt=%b want 0010", gnt);
        else n_pass++;
        #2;
        res = 1'b1;
        #1;
        n_total++;
        if (gnt !== 4'b0000 || gnt_valid !== 1'b0 || gnt_end !== 1'b0)
            $display("FAIL midrst_async gnt=%b valid=%b end=%b want 0000/0/0", gnt, gnt_valid, gnt_end);
        else n_pass++;
        @(negedge clk);
        res = 1'b0;
        model_reset();
        step(4'b0011);
        n_total++;
        if (gnt !== 4'b0001) $display("FAIL midrst_first gnt=%b want 0001", gnt);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [N-1:0] r;
        logic [N-1:0] e_gnt;
        logic [N+IW+3:0] got, exp;
        int bad;
        do_reset();
        r = '0; bad = 0;
        for (int c = 0; c < 500; c++) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 5) == 0) r[i] = ~r[i];
            step(r);
            e_gnt = '0;
            if (m_owner >= 0) e_gnt[m_owner] = 1'b1;
            exp = {e_gnt, (m_owner >= 0), m_idx[IW-1:0], m_start, m_end, m_to};
            got = {gnt, gnt_valid, gnt_idx, gnt_start, gnt_end, timeout};
            n_total++;
            if (got !== exp) begin
                if (bad < 10)
                    $display("FAIL random cyc=%0d req=%b got gnt/v/idx/s/e/to=%b want %b", c, r, got, exp);
                bad++;
            end else n_pass++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        res = 1'b1;
        req = '0;
        model_reset();
        test_reset();
        test_rotation();
        test_timeout();
        test_same_edge();
        test_sparse();
        test_reset_mid_grant();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
